writeback_queue: RTL and testbench

//  Buffers completed results from the ALU and load paths and drains them, one per cycle, into the

---
 rtl/writeback_queue.sv | 141 ++++++++++++++
 tb/tb_writeback_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue
//   Small circular buffer between the ALU/load result paths and the register
//   file write port (Register A). One result is accepted per cycle (the load
//   path has fixed priority), and the head entry is driven onto the write port
//   and popped at every rising edge while the queue is non-empty. Control
//   logic can look up outstanding writes to read addresses B and C.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   -> o_bypass_data_b/c return the data of the youngest queued
//                  entry whose address matches the query, or 0 if none does
//     undefined -> o_bypass_data_b/c are tied to 0
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_alu_valid/addr/data       ALU result offer;  o_alu_ready handshake
//   i_ld_valid/addr/data        load result offer; o_ld_ready handshake
//   o_address_reg_a             register file write address (head entry)
//   o_wenable_reg_a             register file write enable (queue non-empty)
//   o_writedata_reg_a           register file write data (head entry)
//   i_query_addr_b/c            read addresses to check for hazards
//   o_pending_b/c               a queued entry targets the query address
//   o_bypass_data_b/c           youngest matching data (bypass builds only)
//   o_count                     entries currently held, 0..DEPTH
module writeback_queue #(
    parameter int REG_WIDTH  = 34,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_alu_valid,
    input  logic [ADDR_WIDTH-1:0] i_alu_addr,
    input  logic [REG_WIDTH-1:0]  i_alu_data,
    output logic                  o_alu_ready,
    input  logic                  i_ld_valid,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [REG_WIDTH-1:0]  i_ld_data,
    output logic                  o_ld_ready,
    output logic [ADDR_WIDTH-1:0] o_address_reg_a,
    output logic                  o_wenable_reg_a,
    output logic [REG_WIDTH-1:0]  o_writedata_reg_a,
    input  logic [ADDR_WIDTH-1:0] i_query_addr_b,
    input  logic [ADDR_WIDTH-1:0] i_query_addr_c,
    output logic                  o_pending_b,
    output logic                  o_pending_c,
    output logic [REG_WIDTH-1:0]  o_bypass_data_b,
    output logic [REG_WIDTH-1:0]  o_bypass_data_c,
    output logic [PTR_WIDTH:0]    o_count
);
    localparam int CW = PTR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [REG_WIDTH-1:0]  mem_data [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [PTR_WIDTH:0]    count;

    logic                  full, empty, push, pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [REG_WIDTH-1:0]  push_data;
    logic [DEPTH-1:0]      entry_valid;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Readiness depends only on queue state and the competing load valid,
    // never on i_alu_valid, so there is no combinational loop via the ALU.
    assign o_ld_ready  = !full;
    assign o_alu_ready = !full && !i_ld_valid;

    assign push      = (i_ld_valid && o_ld_ready) || (i_alu_valid && o_alu_ready);
    assign push_addr = i_ld_valid ? i_ld_addr : i_alu_addr;
    assign push_data = i_ld_valid ? i_ld_data : i_alu_data;
    assign pop       = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are qualified by count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_WIDTH-1:0] ofs;
            ofs = PTR_WIDTH'(i) - rd_ptr;
            entry_valid[i] = (CW'(ofs) < count);
        end
    end

    always_comb begin
        o_wenable_reg_a   = !empty;
        o_address_reg_a   = empty ? '0 : mem_addr[rd_ptr];
        o_writedata_reg_a = empty ? '0 : mem_data[rd_ptr];
        o_count           = count;
    end

    always_comb begin
        o_pending_b = 1'b0;
        o_pending_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && mem_addr[i] == i_query_addr_b) o_pending_b = 1'b1;
            if (entry_valid[i] && mem_addr[i] == i_query_addr_c) o_pending_c = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Walk from oldest to youngest so the last match (youngest) wins.
    always_comb begin
        o_bypass_data_b = '0;
        o_bypass_data_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_WIDTH-1:0] idx;
            idx = rd_ptr + PTR_WIDTH'(k);
            if (CW'(k) < count) begin
                if (mem_addr[idx] == i_query_addr_b) o_bypass_data_b = mem_data[idx];
                if (mem_addr[idx] == i_query_addr_c) o_bypass_data_c = mem_data[idx];
            end
        end
    end
`else
    assign o_bypass_data_b = '0;
    assign o_bypass_data_c = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed steps followed by a randomized run, all
// compared against a queue-based model of the write-back buffer.
module tb_writeback_queue;
    localparam int RW = 34, AW = 5, DEPTH = 4, PW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, ld_valid, alu_ready, ld_ready;
    logic [AW-1:0] alu_addr, ld_addr, qb, qc, wa;
    logic [RW-1:0] alu_data, ld_data, wd, byp_b, byp_c;
    logic          we, pend_b, pend_c;
    logic [PW:0]   cnt;

    writeback_queue #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .i_alu_valid(alu_valid), .i_alu_addr(alu_addr), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
        .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
        .o_address_reg_a(wa), .o_wenable_reg_a(we), .o_writedata_reg_a(wd),
        .i_query_addr_b(qb), .i_query_addr_c(qc),
        .o_pending_b(pend_b), .o_pending_c(pend_c),
        .o_bypass_data_b(byp_b), .o_bypass_data_c(byp_c), .o_count(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [RW-1:0] d;
    } entry_t;

    entry_t model[$];
    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending(input logic [AW-1:0] q);
        foreach (model[i]) if (model[i].a == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [RW-1:0] bypass(input logic [AW-1:0] q);
        logic [RW-1:0] r = '0;
`ifdef WB_BYPASS_EN
        foreach (model[i]) if (model[i].a == q) r = model[i].d;
`endif
        return r;
    endfunction

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the
    // model to match what the upcoming rising edge does.
    task automatic step(input bit r, input bit lv, input logic [AW-1:0] la, input logic [RW-1:0] ld,
                        input bit av, input logic [AW-1:0] aa, input logic [RW-1:0] ad,
                        input logic [AW-1:0] b, input logic [AW-1:0] c, input bit chk);
        bit exp_ldr, exp_alr;
        rst = r; ld_valid = lv; ld_addr = la; ld_data = ld;
        alu_valid = av; alu_addr = aa; alu_data = ad; qb = b; qc = c;
        @(negedge clk);
        exp_ldr = (model.size() < DEPTH);
        exp_alr = exp_ldr && !lv;
        if (chk) begin
            check("ld_ready", 64'(ld_ready), 64'(exp_ldr));
            check("alu_ready", 64'(alu_ready), 64'(exp_alr));
            check("wenable", 64'(we), 64'(model.size() != 0));
            check("waddr", 64'(wa), model.size() != 0 ? 64'(model[0].a) : 64'd0);
            check("wdata", 64'(wd), model.size() != 0 ? 64'(model[0].d) : 64'd0);
            check("count", 64'(cnt), 64'(model.size()));
            check("pending_b", 64'(pend_b), 64'(pending(b)));
            check("pending_c", 64'(pend_c), 64'(pending(c)));
            check("bypass_b", 64'(byp_b), 64'(bypass(b)));
            check("bypass_c", 64'(byp_c), 64'(bypass(c)));
        end
        if (r) model.delete();
        else begin
            if (model.size() != 0) void'(model.pop_front());
            if (lv && exp_ldr) model.push_back('{a: la, d: ld});
            else if (av && exp_alr) model.push_back('{a: aa, d: ad});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] b, input logic [AW-1:0] c);
        step(0, 0, '0, '0, 0, '0, '0, b, c, 1);
    endtask

    initial begin
        // reset held two cycles with both valids high; first cycle state is unknown
        step(1, 1, 5'd1, 34'h11, 1, 5'd2, 34'h22, 5'd1, 5'd2, 0);
        step(1, 1, 5'd1, 34'h11, 1, 5'd2, 34'h22, 5'd1, 5'd2, 1);
        idle(5'd0, 5'd0);
        check("post_reset_ld_ready", 64'(ld_ready), 64'd1);
        check("post_reset_alu_ready", 64'(alu_ready), 64'd1);

        // single ALU write
        step(0, 0, '0, '0, 1, 5'd5, 34'h1_2345_6789, 5'd5, 5'd0, 1);
        check("single_we", 64'(we), 64'd1);
        check("single_addr", 64'(wa), 64'd5);
        check("single_data", 64'(wd), 64'h1_2345_6789);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);
        check("single_drained", 64'(cnt), 64'd0);

        // contention: load wins, ALU retries
        step(0, 1, 5'd3, 34'hA, 1, 5'd7, 34'hB, 5'd3, 5'd7, 1);
        step(0, 0, '0, '0, 1, 5'd7, 34'hB, 5'd3, 5'd7, 1);
        idle(5'd3, 5'd7);
        idle(5'd3, 5'd7);

        // burst of six back-to-back pushes, pointers wrap
        for (int i = 1; i <= 6; i++)
            step(0, i[0], 5'(i), 34'(i * 16'h101), !i[0], 5'(i + 10), 34'(i * 16'h202), 5'(i), 5'(i + 10), 1);
        idle(5'd6, 5'd16);
        idle(5'd6, 5'd16);

        // hazard on r9 with two writes in flight
        step(0, 0, '0, '0, 1, 5'd9, 34'h1, 5'd9, 5'd4, 1);
        step(0, 0, '0, '0, 1, 5'd9, 34'h2, 5'd9, 5'd4, 1);
        idle(5'd9, 5'd4);
        idle(5'd9, 5'd4);
        check("hazard_cleared", 64'(pend_b), 64'd0);

        // reset mid-drain
        step(0, 1, 5'd20, 34'h3_0000_0001, 0, '0, '0, 5'd20, 5'd21, 1);
        step(0, 1, 5'd21, 34'h3_0000_0002, 0, '0, '0, 5'd20, 5'd21, 1);
        step(0, 0, '0, '0, 1, 5'd22, 34'h3_0000_0003, 5'd22, 5'd21, 1);
        step(1, 1, 5'd23, 34'h4, 0, '0, '0, 5'd22, 5'd23, 1);
        check("rst_mid_we", 64'(we), 64'd0);
        check("rst_mid_count", 64'(cnt), 64'd0);
        idle(5'd22, 5'd23);

        // randomized traffic over a narrow address range to provoke matches
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                 {2'($urandom), $urandom}, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                 {2'($urandom), $urandom}, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
